tinycore_mem_resp: RTL and testbench

TINYCORE_MEM_RESP -- requirements
Module: tinycore_mem_resp

---
 rtl/tinycore_pkg.sv | 62 ++++++
 rtl/tinycore_fifo.sv | 66 ++++++
 rtl/tinycore_mem_resp.sv | 164 ++++++++++++++++
 tb/tb_tinycore_mem_resp.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycore_pkg.sv
// Shared constants and helpers for the tinycore memory/response block:
// register map, STATUS bit positions and the address decoder.
package tinycore_pkg;

   localparam logic [7:0] RAM_TOP     = 8'hEF;
   localparam logic [7:0] ADDR_STATUS = 8'hF0;
   localparam logic [7:0] ADDR_TXDATA = 8'hF1;
   localparam logic [7:0] ADDR_TCOUNT = 8'hF2;
   localparam logic [7:0] ADDR_TCMP   = 8'hF3;
   localparam int         RAM_BYTES   = 240;

   localparam int ST_FULL   = 0;
   localparam int ST_EMPTY  = 1;
   localparam int ST_TFLAG  = 2;
   localparam int ST_CNT_LO = 3;
   localparam int ST_CNT_HI = 5;
   localparam int ST_OVF    = 7;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_STATUS,
      REG_TXDATA,
      REG_TCOUNT,
      REG_TCMP,
      REG_RSVD
   } region_t;

   function automatic region_t decode(input logic [7:0] a);
      region_t r;
      r = REG_RSVD;
      if (a <= RAM_TOP) begin
         r = REG_RAM;
      end else begin
         case (a)
            ADDR_STATUS: r = REG_STATUS;
            ADDR_TXDATA: r = REG_TXDATA;
            ADDR_TCOUNT: r = REG_TCOUNT;
            ADDR_TCMP:   r = REG_TCMP;
            default:     r = REG_RSVD;
         endcase
      end
      return r;
   endfunction

   function automatic logic [7:0] status_pack(
      input logic       full,
      input logic       empty,
      input logic       tflag,
      input logic [2:0] cnt,
      input logic       ovf
   );
      logic [7:0] s;
      s = '0;
      s[ST_FULL]             = full;
      s[ST_EMPTY]            = empty;
      s[ST_TFLAG]            = tflag;
      s[ST_CNT_HI:ST_CNT_LO] = cnt;
      s[ST_OVF]              = ovf;
      return s;
   endfunction

endpackage

// File: rtl/tinycore_fifo.sv
// Small synchronous FIFO: registered count, no fall-through, head data
// forced to zero while empty so the output is clean straight out of reset.
module tinycore_fifo
   import tinycore_pkg::*;
#(
   parameter int DATA_SZ = 8,
   parameter int DEPTH   = 4,
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [DATA_SZ-1:0] push_data,
   output logic [DATA_SZ-1:0] head,
   output logic               full,
   output logic               empty,
   output logic [CNT_W-1:0]   count
);

   localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_SZ-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               do_push;
   logic               do_pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign count = count_reg;
   assign head  = empty ? '0 : mem[rd_ptr_reg];

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/tinycore_mem_resp.sv
// Core-side memory responder: 240-byte RAM, STATUS/TXDATA/TCOUNT/TCMP
// registers, an output byte FIFO and a compare-match interval timer.
module tinycore_mem_resp
   import tinycore_pkg::*;
#(
   parameter int ADDR_SZ    = 8,
   parameter int DATA_SZ    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_SZ-1:0] addr,
   input  logic [DATA_SZ-1:0] data_i,
   input  logic               we,
   output logic [DATA_SZ-1:0] data_o,
   output logic [DATA_SZ-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [7:0]         addr_lo;
   logic               in_page;
   region_t            region;
   logic [7:0]         ram_idx;

   logic               wr_ram;
   logic               wr_status;
   logic               wr_tx;
   logic               wr_tcount;
   logic               wr_tcmp;

   logic               fifo_push;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic               pop_now;
   logic [7:0]         status_now;

   logic [DATA_SZ-1:0] ram [RAM_BYTES];
   logic [DATA_SZ-1:0] ram_rd_reg;
   logic               sel_ram_reg;
   logic [DATA_SZ-1:0] reg_rd_reg;
   logic [DATA_SZ-1:0] reg_rd_next;

   logic [DATA_SZ-1:0] tcount_reg;
   logic [DATA_SZ-1:0] tcount_next;
   logic [DATA_SZ-1:0] tcmp_reg;
   logic               timer_flag_reg;
   logic               timer_flag_next;
   logic               timer_wrap;
   logic               overflow_reg;
   logic               overflow_next;
   logic               overflow_set;

   assign addr_lo = addr[7:0];

   // Anything above the 8-bit page aliases to reserved space.
   generate
      if (ADDR_SZ > 8) begin : g_hi_addr
         assign in_page = (addr[ADDR_SZ-1:8] == '0);
      end else begin : g_no_hi_addr
         assign in_page = 1'b1;
      end
   endgenerate

   always_comb begin
      region = REG_RSVD;
      if (in_page) begin
         region = decode(addr_lo);
      end
   end

   assign ram_idx   = (region == REG_RAM) ? addr_lo : 8'd0;
   assign wr_ram    = we && (region == REG_RAM);
   assign wr_status = we && (region == REG_STATUS);
   assign wr_tx     = we && (region == REG_TXDATA);
   assign wr_tcount = we && (region == REG_TCOUNT);
   assign wr_tcmp   = we && (region == REG_TCMP);

   assign fifo_push = wr_tx && !rst;
   assign pop_now   = out_ready && !fifo_empty;
   assign out_valid = !fifo_empty;

   tinycore_fifo #(
      .DATA_SZ (DATA_SZ),
      .DEPTH   (FIFO_DEPTH),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .pop       (out_ready),
      .push_data (data_i),
      .head      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign status_now = status_pack(fifo_full, fifo_empty, timer_flag_reg,
                                   3'(fifo_count), overflow_reg);

   // RAM has no reset; registered read returns the pre-write byte on a collision.
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         ram[ram_idx] <= data_i;
      end
      ram_rd_reg <= ram[ram_idx];
   end

   always_comb begin
      reg_rd_next = '0;
      case (region)
         REG_STATUS: reg_rd_next = DATA_SZ'(status_now);
         REG_TCOUNT: reg_rd_next = tcount_reg;
         REG_TCMP:   reg_rd_next = tcmp_reg;
         default:    reg_rd_next = '0;
      endcase
   end

   // A TCOUNT write overrides the whole wrap event, flag included.
   assign timer_wrap = (tcmp_reg != '0) && (tcount_reg == tcmp_reg) && !wr_tcount;

   always_comb begin
      tcount_next = tcount_reg + DATA_SZ'(1);
      if (wr_tcount) begin
         tcount_next = data_i;
      end else if ((tcmp_reg == '0) || timer_wrap) begin
         tcount_next = '0;
      end
   end

   // Sticky flags: a set event in the same cycle beats a software clear.
   assign timer_flag_next = timer_wrap ||
                            (timer_flag_reg && !(wr_status && data_i[ST_TFLAG]));
   assign overflow_set    = wr_tx && fifo_full && !pop_now;
   assign overflow_next   = overflow_set ||
                            (overflow_reg && !(wr_status && data_i[ST_OVF]));

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_ram_reg    <= 1'b0;
         reg_rd_reg     <= '0;
         tcount_reg     <= '0;
         tcmp_reg       <= '0;
         timer_flag_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         sel_ram_reg    <= (region == REG_RAM);
         reg_rd_reg     <= reg_rd_next;
         tcount_reg     <= tcount_next;
         timer_flag_reg <= timer_flag_next;
         overflow_reg   <= overflow_next;
         if (wr_tcmp) begin
            tcmp_reg <= data_i;
         end
      end
   end

   assign data_o = sel_ram_reg ? ram_rd_reg : reg_rd_reg;

endmodule

// File: tb/tb_tinycore_mem_resp.sv
// Scoreboard bench: stimulus pushes expected read data and FIFO bytes from a
// queue-based reference model; a negedge monitor pops and compares.
module tb_tinycore_mem_resp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] addr = 8'h00;
   logic [7:0] data_i = 8'h00;
   logic [7:0] data_o;
   logic [7:0] out_data;

   always #5 clk = ~clk;

   tinycore_mem_resp #(
      .ADDR_SZ    (8),
      .DATA_SZ    (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .data_i    (data_i),
      .we        (we),
      .data_o    (data_o),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   typedef struct {
      logic       chk;
      logic [7:0] val;
      logic [7:0] a;
      int         id;
   } rd_exp_t;

   rd_exp_t    rd_q[$];
   logic [7:0] fifo_sb[$];
   int         tests = 0;
   int         fails = 0;

   logic [7:0] m_ram [256];
   bit         m_known [256];
   logic [7:0] m_fifo[$];
   logic       m_flag = 1'b0;
   logic       m_ovf = 1'b0;
   logic [7:0] m_tcount = 8'h00;
   logic [7:0] m_tcmp = 8'h00;

   rd_exp_t    pend;
   bit         pend_valid = 1'b0;
   int         step_id = 0;

   function automatic rd_exp_t model_read(input logic [7:0] a);
      rd_exp_t e;
      int      s;
      e.chk = 1'b1;
      e.val = 8'h00;
      e.a   = a;
      e.id  = step_id;
      if (a < 8'hF0) begin
         e.chk = m_known[a];
         e.val = m_ram[a];
      end else if (a == 8'hF0) begin
         s = (m_fifo.size() == 4 ? 1 : 0) + (m_fifo.size() == 0 ? 2 : 0)
           + (m_flag ? 4 : 0) + m_fifo.size() * 8 + (m_ovf ? 128 : 0);
         e.val = 8'(s);
      end else if (a == 8'hF2) begin
         e.val = m_tcount;
      end else if (a == 8'hF3) begin
         e.val = m_tcmp;
      end
      return e;
   endfunction

   task automatic model_update(input logic r, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input logic rdy);
      bit pop;
      bit push;
      bit wrap;
      if (w && a < 8'hF0) begin
         m_ram[a]   = d;
         m_known[a] = 1'b1;
      end
      if (r) begin
         m_fifo.delete();
         fifo_sb.delete();
         m_flag   = 1'b0;
         m_ovf    = 1'b0;
         m_tcount = 8'h00;
         m_tcmp   = 8'h00;
      end else begin
         pop  = (m_fifo.size() > 0) && rdy;
         push = w && (a == 8'hF1);
         wrap = (m_tcmp != 8'h00) && (m_tcount == m_tcmp);
         if (push && m_fifo.size() == 4 && !pop) m_ovf = 1'b1;
         else if (w && a == 8'hF0 && d[7]) m_ovf = 1'b0;
         if (pop) void'(m_fifo.pop_front());
         if (push && m_fifo.size() < 4) begin
            m_fifo.push_back(d);
            fifo_sb.push_back(d);
         end
         if (wrap) m_flag = 1'b1;
         else if (w && a == 8'hF0 && d[2]) m_flag = 1'b0;
         if (w && a == 8'hF2) m_tcount = d;
         else if (m_tcmp == 8'h00 || wrap) m_tcount = 8'h00;
         else m_tcount = m_tcount + 8'd1;
         if (w && a == 8'hF3) m_tcmp = d;
      end
   endtask

   // One clock of stimulus; 'fixed' replaces the model's read expectation by exp_val.
   task automatic step(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic rdy, input bit fixed, input logic [7:0] exp_val);
      @(posedge clk);
      #1;
      if (pend_valid) rd_q.push_back(pend);
      rst       = r;
      we        = w;
      addr      = a;
      data_i    = d;
      out_ready = rdy;
      step_id++;
      pend = model_read(a);
      if (r) begin
         pend.chk = 1'b1;
         pend.val = 8'h00;
      end else if (fixed) begin
         pend.chk = 1'b1;
         pend.val = exp_val;
      end
      pend_valid = 1'b1;
      model_update(r, w, a, d, rdy);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b0, 1'b1, a, d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b0, 1'b0, a, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic rdx(input logic [7:0] a, input logic [7:0] exp_val);
      step(1'b0, 1'b0, a, 8'h00, 1'b0, 1'b1, exp_val);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic reset_cycle();
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_val);
      tests++;
      if (act !== exp_val) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp_val);
      end
   endtask

   always @(negedge clk) begin : monitor
      rd_exp_t    e;
      logic [7:0] x;
      if (rd_q.size() > 0) begin
         e = rd_q.pop_front();
         if (e.chk) begin
            tests++;
            if (data_o !== e.val) begin
               fails++;
               $display("FAIL read step %0d addr %02h: data_o %02h expected %02h",
                        e.id, e.a, data_o, e.val);
            end
         end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         tests++;
         if (fifo_sb.size() == 0) begin
            fails++;
            $display("FAIL fifo_pop: out_data %02h presented, expected no byte", out_data);
         end else begin
            x = fifo_sb.pop_front();
            if (out_data !== x) begin
               fails++;
               $display("FAIL fifo_pop: out_data %02h expected %02h", out_data, x);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic       r;
      logic       w;
      logic       rdy;
      logic [7:0] a;
      logic [7:0] d;
      int         sel;

      reset_cycle();
      reset_cycle();

      // RAM write/read, reserved space, read-during-write
      wr(8'h10, 8'hA5);
      rdx(8'h10, 8'hA5);
      wr(8'hF8, 8'h55);
      rdx(8'hF8, 8'h00);
      step(1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b1, 8'hA5);
      rdx(8'h10, 8'h3C);
      wr(8'h10, 8'hA5);
      rdx(8'hF1, 8'h00);

      // Fill past full, then drain in order
      for (int k = 1; k <= 5; k++) wr(8'hF1, 8'(k));
      rdx(8'hF0, 8'hA1);
      drain(4);
      rdx(8'hF0, 8'h82);
      wr(8'hF0, 8'h80);
      rdx(8'hF0, 8'h02);

      // Push and pop together while full
      for (int k = 0; k < 4; k++) wr(8'hF1, 8'h11 + 8'(k));
      step(1'b0, 1'b1, 8'hF1, 8'h77, 1'b1, 1'b0, 8'h00);
      rdx(8'hF0, 8'h21);
      drain(4);
      rdx(8'hF0, 8'h02);

      // Timer wrap, flag clear, clear colliding with a wrap
      reset_cycle();
      wr(8'hF3, 8'h03);
      rdx(8'hF2, 8'h00);
      rdx(8'hF2, 8'h01);
      rdx(8'hF2, 8'h02);
      rdx(8'hF2, 8'h03);
      rdx(8'hF2, 8'h00);
      rdx(8'hF0, 8'h06);
      wr(8'hF0, 8'h04);
      rdx(8'hF0, 8'h02);
      rdx(8'hF0, 8'h06);
      rd(8'hF2);
      rd(8'hF2);
      wr(8'hF0, 8'h04);
      rdx(8'hF0, 8'h06);

      // Reset mid-operation with FIFO data, running timer and a same-cycle push
      wr(8'hF3, 8'h20);
      wr(8'hF1, 8'hAA);
      wr(8'hF1, 8'hBB);
      wr(8'hF2, 8'h05);
      step(1'b1, 1'b1, 8'hF1, 8'h99, 1'b0, 1'b0, 8'h00);
      rdx(8'hF0, 8'h02);
      check("reset_out_valid", {7'd0, out_valid}, 8'h00);
      check("reset_out_data", out_data, 8'h00);
      rdx(8'hF2, 8'h00);
      rdx(8'hF3, 8'h00);
      rdx(8'h10, 8'hA5);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 199) == 0);
         w   = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel < 4)      a = 8'($urandom_range(0, 31));
         else if (sel < 6) a = 8'hF1;
         else if (sel < 8) a = 8'hF0 + 8'($urandom_range(0, 3));
         else              a = 8'($urandom_range(0, 255));
         d = 8'($urandom);
         if (a == 8'hF3 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 6));
         if (w && a == 8'hF2 && m_tcmp != 8'h00 && m_tcount == m_tcmp) w = 1'b0;
         if (r) rdy = 1'b0;
         else if (((i / 250) % 2) == 1) rdy = ($urandom_range(0, 3) != 0);
         else rdy = ($urandom_range(0, 7) == 0);
         step(r, w, a, d, rdy, 1'b0, 8'h00);
      end

      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 8'hF0, 8'h00, 1'b1, 1'b0, 8'h00);
      rd(8'hF0);
      @(posedge clk);
      #1;
      rd_q.push_back(pend);
      pend_valid = 1'b0;
      out_ready  = 1'b0;
      @(negedge clk);
      #1;
      check("fifo_sb_left", 8'(fifo_sb.size()), 8'h00);
      check("rd_q_left", 8'(rd_q.size()), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
